// File: rtl/deblock_edge_scheduler.sv
// Deblocking edge scheduler: walks the 8x8 grid, issuing vertical then horizontal edge jobs.
// Optional perf counters are compiled in with DEBLK_SCHED_PERF_EN.
module deblock_edge_scheduler #(
  parameter int MAX_WIDTH       = 128,
  parameter int MAX_HEIGHT      = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  input  logic [5:0]  filter_level,
  input  logic [2:0]  sharpness,
  output logic        busy,
  output logic        done,
  output logic        job_valid,
  input  logic        job_ready,
  output logic [15:0] job_x,
  output logic [15:0] job_y,
  output logic        job_dir,
  output logic [5:0]  job_limit,
  output logic [7:0]  job_blimit,
  output logic [1:0]  job_thresh,
  input  logic        job_done
`ifdef DEBLK_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls
`endif
);

  localparam logic [13:0] MAX_COLS = 14'(MAX_WIDTH / 8);
  localparam logic [13:0] MAX_ROWS = 14'(MAX_HEIGHT / 8);
  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_VERT, S_DRAIN_V, S_HORZ, S_DRAIN_H, S_DONE
  } state_t;

  function automatic logic [5:0] f_limit(input logic [5:0] level, input logic [2:0] sharp);
    logic [5:0] lim;
    logic [5:0] cap;
    if (sharp > 3'd4)
      lim = level >> 2;
    else if (sharp != 3'd0)
      lim = level >> 1;
    else
      lim = level;
    cap = 6'd9 - {3'd0, sharp};
    if ((sharp != 3'd0) && (lim > cap))
      lim = cap;
    if (lim == 6'd0)
      lim = 6'd1;
    return lim;
  endfunction

  function automatic logic [7:0] f_blimit(input logic [5:0] level, input logic [5:0] lim);
    return {1'b0, level, 1'b0} + 8'd4 + {2'b00, lim};
  endfunction

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_job_valid;
  logic [3:0]  r_out;
  logic [12:0] r_bx;
  logic [12:0] r_by;
  logic        r_dir;
  logic [12:0] r_cols;
  logic [12:0] r_rows;
  logic [5:0]  r_level;
  logic [2:0]  r_sharp;
  logic [5:0]  r_limit;
  logic [7:0]  r_blimit;
  logic [1:0]  r_thresh;

  logic [13:0] w_cols_raw;
  logic [13:0] w_rows_raw;
  logic [12:0] w_cols;
  logic [12:0] w_rows;
  logic        w_acc;
  logic        w_dn;
  logic [3:0]  w_out_nxt;
  logic        w_out_ok;
  logic        w_last_col;
  logic        w_last_row;
  logic [5:0]  w_lim;

  always_comb begin
    w_cols_raw = 14'((17'(frame_width) + 17'd7) >> 3);
    w_rows_raw = 14'((17'(frame_height) + 17'd7) >> 3);
    w_cols     = (w_cols_raw > MAX_COLS) ? MAX_COLS[12:0] : w_cols_raw[12:0];
    w_rows     = (w_rows_raw > MAX_ROWS) ? MAX_ROWS[12:0] : w_rows_raw[12:0];
    // A completion with nothing in flight is a stray and must not wrap the counter
    w_acc      = r_job_valid && job_ready;
    w_dn       = job_done && (r_out != 4'd0);
    w_out_nxt  = r_out + {3'd0, w_acc} - {3'd0, w_dn};
    w_out_ok   = (w_out_nxt < MAX_OUT);
    w_last_col = (r_bx == (r_cols - 13'd1));
    w_last_row = (r_by == (r_rows - 13'd1));
    w_lim      = f_limit(r_level, r_sharp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_job_valid <= 1'b0;
      r_out       <= 4'd0;
      r_bx        <= 13'd0;
      r_by        <= 13'd0;
      r_dir       <= 1'b0;
      r_cols      <= 13'd0;
      r_rows      <= 13'd0;
      r_level     <= 6'd0;
      r_sharp     <= 3'd0;
      r_limit     <= 6'd0;
      r_blimit    <= 8'd0;
      r_thresh    <= 2'd0;
    end else begin
      r_out <= w_out_nxt;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_level <= filter_level;
            r_sharp <= sharpness;
            r_cols  <= w_cols;
            r_rows  <= w_rows;
            r_busy  <= 1'b1;
            r_state <= S_CFG;
          end
        end
        // ---- per-frame thresholds and first vertical position ----
        S_CFG: begin
          r_limit  <= w_lim;
          r_blimit <= f_blimit(r_level, w_lim);
          r_thresh <= r_level[5:4];
          r_dir    <= 1'b0;
          r_bx     <= 13'd1;
          r_by     <= 13'd0;
          if ((r_level == 6'd0) || (r_cols == 13'd0) || (r_rows == 13'd0)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cols == 13'd1) begin
            r_state <= S_DRAIN_V;
          end else begin
            r_job_valid <= w_out_ok;
            r_state     <= S_VERT;
          end
        end
        // ---- vertical pass: bx starts at 1, skipping the frame's left border ----
        S_VERT: begin
          r_job_valid <= w_out_ok;
          if (w_acc) begin
            if (w_last_col) begin
              if (w_last_row) begin
                r_job_valid <= 1'b0;
                r_state     <= S_DRAIN_V;
              end else begin
                r_bx <= 13'd1;
                r_by <= r_by + 13'd1;
              end
            end else begin
              r_bx <= r_bx + 13'd1;
            end
          end
        end
        // ---- horizontal filtering reads vertically filtered pixels ----
        S_DRAIN_V: begin
          if (r_out == 4'd0) begin
            r_dir <= 1'b1;
            r_bx  <= 13'd0;
            r_by  <= 13'd1;
            if (r_rows == 13'd1) begin
              r_state <= S_DRAIN_H;
            end else begin
              r_job_valid <= w_out_ok;
              r_state     <= S_HORZ;
            end
          end
        end
        S_HORZ: begin
          r_job_valid <= w_out_ok;
          if (w_acc) begin
            if (w_last_col) begin
              if (w_last_row) begin
                r_job_valid <= 1'b0;
                r_state     <= S_DRAIN_H;
              end else begin
                r_bx <= 13'd0;
                r_by <= r_by + 13'd1;
              end
            end else begin
              r_bx <= r_bx + 13'd1;
            end
          end
        end
        S_DRAIN_H: begin
          if (r_out == 4'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_job_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign job_valid  = r_job_valid;
  assign job_x      = {r_bx, 3'b000};
  assign job_y      = {r_by, 3'b000};
  assign job_dir    = r_dir;
  assign job_limit  = r_limit;
  assign job_blimit = r_blimit;
  assign job_thresh = r_thresh;

`ifdef DEBLK_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;
  logic        w_blocked;

  assign w_blocked = ((r_state == S_VERT) || (r_state == S_HORZ)) && !r_job_valid &&
                     (r_out == MAX_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles <= 32'd0;
      r_perf_stalls <= 32'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_perf_cycles <= 32'd0;
      r_perf_stalls <= 32'd0;
    end else begin
      if (r_busy)
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_job_valid && !job_ready) || w_blocked)
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_deblock_edge_scheduler.sv
// Directed bench for deblock_edge_scheduler with MAX_OUTSTANDING=2 and an auto-completing job sink.
module tb_deblock_edge_scheduler;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] frame_width = 16'd0;
  logic [15:0] frame_height = 16'd0;
  logic [5:0]  filter_level = 6'd0;
  logic [2:0]  sharpness = 3'd0;
  logic        busy;
  logic        done;
  logic        job_valid;
  logic        job_ready = 1'b1;
  logic [15:0] job_x;
  logic [15:0] job_y;
  logic        job_dir;
  logic [5:0]  job_limit;
  logic [7:0]  job_blimit;
  logic [1:0]  job_thresh;
  logic        job_done = 1'b0;

  always #5 clk = ~clk;

  deblock_edge_scheduler #(
    .MAX_WIDTH(128), .MAX_HEIGHT(128), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_width(frame_width), .frame_height(frame_height),
    .filter_level(filter_level), .sharpness(sharpness),
    .busy(busy), .done(done),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_dir(job_dir),
    .job_limit(job_limit), .job_blimit(job_blimit), .job_thresh(job_thresh),
    .job_done(job_done)
  );

  typedef struct {
    int x; int y; int dir; int lim; int blim; int thr; int cyc;
  } job_t;

  job_t jobs[$];
  int   due[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   rcyc = 0;
  int   done_cnt = 0;
  int   valid_cnt = 0;
  int   model_out = 0;
  int   last_dir = 0;
  int   hv_err = 0;
  int   max_err = 0;
  int   stab_err = 0;
  int   done_dly = 0;
  int   stray_cnt = 0;
  int   stray_seen = 0;
  logic        hold = 1'b0;
  logic [15:0] hx = 16'd0;
  logic [15:0] hy = 16'd0;
  logic        hdir = 1'b0;

  // Job sink: completes each accepted job done_dly cycles later, plus injected stray pulses.
  initial forever begin
    @(posedge clk);
    rcyc++;
    if (rst)
      due.delete();
    else if (job_valid && job_ready)
      due.push_back(rcyc + done_dly);
    #1;
    job_done = 1'b0;
    if (stray_seen != stray_cnt) begin
      job_done   = 1'b1;
      stray_seen = stray_cnt;
    end else if (due.size() > 0 && due[0] <= rcyc) begin
      job_done = 1'b1;
      void'(due.pop_front());
    end
  end

  // Observer: logs accepted jobs and tracks in-flight count, ordering and stall stability.
  initial forever begin
    int inc;
    int dec;
    job_t j;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_out = 0;
      hold      = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (job_valid) begin
        valid_cnt++;
        if (model_out >= MAXO) max_err++;
        if (job_dir && model_out > 0 && last_dir == 0) hv_err++;
      end
      if (hold && (!job_valid || job_x != hx || job_y != hy || job_dir != hdir)) stab_err++;
      hold = job_valid && !job_ready;
      hx   = job_x;
      hy   = job_y;
      hdir = job_dir;
      inc  = (job_valid && job_ready) ? 1 : 0;
      dec  = (job_done && model_out > 0) ? 1 : 0;
      if (inc == 1) begin
        j.x = int'(job_x); j.y = int'(job_y); j.dir = int'(job_dir);
        j.lim = int'(job_limit); j.blim = int'(job_blimit); j.thr = int'(job_thresh);
        j.cyc = cyc;
        jobs.push_back(j);
        last_dir = j.dir;
      end
      model_out = model_out + inc - dec;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input int w, input int h, input int lvl, input int sh);
    frame_width  = 16'(w);
    frame_height = 16'(h);
    filter_level = 6'(lvl);
    sharpness    = 3'(sh);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int snap;
    bit ok;
    snap = done_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt != snap) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 1);
  endtask

  function automatic bit job_ok(input job_t j, input int x, input int y, input int d,
                                input int lim, input int blim, input int thr);
    return (j.x == x) && (j.y == y) && (j.dir == d) &&
           (j.lim == lim) && (j.blim == blim) && (j.thr == thr);
  endfunction

  task automatic check_frame(input string tag, input int base, input int cols, input int rows,
                             input int lim, input int blim, input int thr);
    int n;
    int exp_n;
    int idx;
    int bad;
    exp_n = (cols - 1) * rows + cols * (rows - 1);
    n     = jobs.size() - base;
    check({tag, "_jobs"}, n, exp_n);
    bad = 0;
    idx = base;
    if (n == exp_n) begin
      for (int by = 0; by < rows; by++)
        for (int bx = 1; bx < cols; bx++) begin
          if (!job_ok(jobs[idx], 8 * bx, 8 * by, 0, lim, blim, thr)) bad++;
          idx++;
        end
      for (int by = 1; by < rows; by++)
        for (int bx = 0; bx < cols; bx++) begin
          if (!job_ok(jobs[idx], 8 * bx, 8 * by, 1, lim, blim, thr)) bad++;
          idx++;
        end
    end else begin
      bad = -1;
    end
    check({tag, "_fields"}, bad, 0);
  endtask

  initial begin
    int base;
    int snap_done;
    int snap_valid;

    // ---- reset state ----
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(job_valid), 0);
    check("rst_x", 32'(job_x), 0);
    check("rst_blimit", 32'(job_blimit), 0);
    rst = 1'b0;
    tick(2);

    // ---- 64x64, level 10, sharp 0, back-to-back ----
    base = jobs.size();
    snap_done = done_cnt;
    done_dly = 0;
    job_ready = 1'b1;
    start_frame(64, 64, 10, 0);
    check("t1_busy_c1", 32'(busy), 1);
    check("t1_valid_c1", 32'(job_valid), 0);
    frame_width  = 16'd8;
    filter_level = 6'd63;
    sharpness    = 3'd7;
    tick(1);
    check("t1_valid_c2", 32'(job_valid), 1);
    check("t1_first_x", 32'(job_x), 8);
    check("t1_first_y", 32'(job_y), 0);
    check("t1_first_dir", 32'(job_dir), 0);
    check("t1_limit", 32'(job_limit), 10);
    check("t1_blimit", 32'(job_blimit), 34);
    check("t1_thresh", 32'(job_thresh), 0);
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("t1_done", 600);
    check("t1_busy_end", 32'(busy), 0);
    tick(3);
    check("t1_done_pulses", done_cnt - snap_done, 1);
    check_frame("t1", base, 8, 8, 10, 34, 0);
    if (jobs.size() - base >= 112) begin
      check("t1_last_x", jobs[base + 111].x, 56);
      check("t1_last_y", jobs[base + 111].y, 56);
      check("t1_last_dir", jobs[base + 111].dir, 1);
      check("t1_first_h_dir", jobs[base + 56].dir, 1);
      check("t1_v_span", jobs[base + 55].cyc - jobs[base].cyc, 55);
      check("t1_h_span", jobs[base + 111].cyc - jobs[base + 56].cyc, 55);
    end

    // ---- limit arithmetic at other levels/sharpness ----
    base = jobs.size();
    start_frame(64, 64, 30, 2);
    wait_done("t2_done", 600);
    check_frame("t2", base, 8, 8, 7, 71, 1);
    tick(2);

    base = jobs.size();
    start_frame(64, 64, 50, 5);
    wait_done("t3_done", 600);
    check_frame("t3", base, 8, 8, 4, 108, 3);
    tick(2);

    // ---- level 0: no jobs, done two cycles after start ----
    snap_done  = done_cnt;
    snap_valid = valid_cnt;
    start_frame(64, 64, 0, 0);
    check("t4_done_c1", 32'(done), 0);
    check("t4_busy_c1", 32'(busy), 1);
    tick(1);
    check("t4_done_c2", 32'(done), 1);
    check("t4_busy_c2", 32'(busy), 0);
    tick(1);
    check("t4_done_c3", 32'(done), 0);
    tick(3);
    check("t4_valid_cycles", valid_cnt - snap_valid, 0);
    check("t4_done_pulses", done_cnt - snap_done, 1);

    // ---- 16x16 with delayed completions ----
    base = jobs.size();
    done_dly = 20;
    start_frame(16, 16, 20, 1);
    wait_done("t5_done", 300);
    check_frame("t5", base, 2, 2, 8, 52, 1);
    if (jobs.size() - base >= 4)
      check("t5_h_after_v", 32'((jobs[base + 2].cyc - jobs[base + 1].cyc) > 20), 1);
    check("t5_hv_order", hv_err, 0);
    tick(2);

    // ---- outstanding limit, stall stability, then reset mid-frame ----
    base = jobs.size();
    done_dly = 1000;
    job_ready = 1'b0;
    start_frame(64, 64, 10, 0);
    tick(1);
    check("t6_valid", 32'(job_valid), 1);
    tick(2);
    check("t6_stall_x", 32'(job_x), 8);
    check("t6_stall_valid", 32'(job_valid), 1);
    job_ready = 1'b1;
    tick(1);
    check("t6_next_x", 32'(job_x), 16);
    job_ready = 1'b0;
    tick(1);
    check("t6_hold_x", 32'(job_x), 16);
    check("t6_hold_dir", 32'(job_dir), 0);
    job_ready = 1'b1;
    tick(1);
    check("t6_full_valid", 32'(job_valid), 0);
    tick(5);
    check("t6_full_valid_late", 32'(job_valid), 0);
    check("t6_accepts", jobs.size() - base, 2);
    check("t6_stability", stab_err, 0);
    check("t6_max_out", max_err, 0);

    rst = 1'b1;
    tick(1);
    check("t6_rst_valid", 32'(job_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    stray_cnt++;
    tick(3);
    check("t6_stray_valid", 32'(job_valid), 0);

    // ---- fresh frame after reset with stray completion already seen ----
    base = jobs.size();
    snap_done = done_cnt;
    done_dly = 0;
    start_frame(64, 64, 10, 0);
    wait_done("t7_done", 600);
    check_frame("t7", base, 8, 8, 10, 34, 0);
    tick(3);
    check("t7_done_pulses", done_cnt - snap_done, 1);
    check("t7_max_out", max_err, 0);
    check("t7_hv_order", hv_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/deblock_edge_scheduler.md
Name: deblock_edge_scheduler

Overview:
- Sequences the AV2 deblocking filter over a frame. Walks the 8x8 block grid and issues one job per interior 8-pixel edge segment to a single-edge filter datapath over a valid/ready handshake.
- Order: all vertical edges first, then all horizontal edges. Derives the per-frame limit, blimit and thresh from filter_level and sharpness.
- Sits between the frame-level control (start/done) and the edge filter core.

Parameters:
- MAX_WIDTH, 128, max frame width in pixels; columns clamp to MAX_WIDTH/8.
- MAX_HEIGHT, 128, max frame height in pixels; rows clamp to MAX_HEIGHT/8.
- MAX_OUTSTANDING, 4, max accepted-but-not-completed jobs (2..15).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  frame start pulse; sampled only in IDLE
- frame_width  in  16  pixels
- frame_height  in  16  pixels
- filter_level  in  6  0 = filter off
- sharpness  in  3  sharpness 0..7
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at frame completion
- job_valid  out  1  job offer
- job_ready  in  1  filter accepts the job
- job_x  out  16  edge segment x (pixel)
- job_y  out  16  edge segment y (pixel)
- job_dir  out  1  0 = vertical edge, 1 = horizontal edge
- job_limit  out  6  inner limit
- job_blimit  out  8  block-edge limit
- job_thresh  out  2  hev threshold
- job_done  in  1  one-cycle pulse per completed job

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, outstanding 0.
- Config captured at start acceptance; input changes while busy are ignored. start while busy is ignored.
- Grid: cols = min((frame_width+7)>>3, MAX_WIDTH/8); rows = min((frame_height+7)>>3, MAX_HEIGHT/8).
- Limit arithmetic (CFG state, registered):
  - shift = sharpness>4 ? 2 : (sharpness>0 ? 1 : 0)
  - lim = level>>shift
  - if sharpness>0: lim = min(lim, 9-sharpness)
  - lim = max(lim, 1)
  - blimit = 2*(level+2)+lim
  - thresh = level>>4
- States:
  - IDLE -> CFG on start.
  - CFG (1 cycle) -> DONE if level==0, cols==0 or rows==0; else -> VERT.
  - VERT: jobs for by=0..rows-1 (outer), bx=1..cols-1 (inner), at x=8*bx, y=8*by, dir=0. If cols<=1, go straight to DRAIN_V.
  - DRAIN_V: wait outstanding==0 -> HORZ.
  - HORZ: by=1..rows-1 (outer), bx=0..cols-1 (inner), dir=1. If rows<=1, go straight to DRAIN_H.
  - DRAIN_H: wait outstanding==0 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Handshake:
  - job fields are registered and held stable while job_valid && !job_ready.
  - Advance on job_valid && job_ready.
  - Back-to-back jobs allowed (one per cycle).
  - job_valid is low when outstanding==MAX_OUTSTANDING.
- Outstanding counter: +1 on accept, -1 on job_done; both in the same cycle leaves it unchanged.
  - job_done at outstanding==0 is ignored (saturates at 0).
- Horizontal-pass ordering: no horizontal job is offered until every vertical job has completed.
- Latency: level 0 -> done pulse 2 cycles after the start cycle; first job_valid 2 cycles after the start cycle.
- rst mid-frame: immediate return to IDLE, job_valid drops, outstanding cleared; subsequent stray job_done are ignored.

Optional Feature:
- DEBLK_SCHED_PERF_EN defined:
  - Adds outputs perf_cycles[31:0] (cycles busy) and perf_stalls[31:0] (cycles with job_valid && !job_ready, plus cycles blocked by MAX_OUTSTANDING).
  - Both clear at start acceptance and hold after done.
  - Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- 64x64, level 10, sharp 0, job_ready=1, job_done 1 cycle after each accept -> 112 jobs (56 V then 56 H); first (8,0,V), last (56,56,H); limit 10, blimit 34, thresh 0; single done pulse.
- level 30, sharp 2, 64x64 -> limit 7, blimit 71, thresh 1 on every job; level 50, sharp 5 -> limit 4, blimit 108, thresh 3.
- level 0, 64x64 -> zero job_valid cycles, done 2 cycles after start, busy back to 0.
- 16x16, level 20, sharp 1, job_done withheld 20 cycles -> V jobs (8,0),(8,8) only until both done; then H jobs (0,8),(8,8); limit 8, blimit 52, thresh 1; 4 jobs total.
- MAX_OUTSTANDING=2, job_done held low -> exactly 2 accepts then job_valid=0. With job_ready toggling, job_x/y/dir stay stable while stalled. A simultaneous accept and job_done keeps outstanding unchanged.
- rst asserted mid-VERT -> next cycle job_valid=0, busy=0; a new start afterwards runs a full correct frame; stray job_done after reset has no effect.
